// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
// Purpose: state encoding, default bit timing and frame width shared by the UART blocks.
// Ports: none (package).
package uart_pkg;

  localparam int DATA_BITS           = 8;
  localparam int DEFAULT_WAIT_CYCLES = 234;  // 27 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a tick on the last cycle of each bit
// Purpose: counts 0..WAIT_CYCLES-1 and wraps, so successive bit periods never drift.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   restart in   hold the counter at 0 (start of a new frame)
//   tick    out  high on the last cycle of the current bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: one byte per handshake, sent LSB first on uart_tx
// Purpose: start bit, 8 data bits, optional even parity (macro UART_TX_PARITY_EN), STOP_BITS stop bits.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   in_data   in   byte to send, captured on in_valid && in_ready
//   in_valid  in   source has a byte
//   in_ready  out  idle and able to accept a byte
//   uart_tx   out  registered serial line, idle high
//   busy      out  frame in progress
//   done      out  one-cycle pulse on the last clock of the final stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic                 tx_next;
  logic                 tick;
  logic                 baud_restart;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_next;
`endif

  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign baud_restart = (state == IDLE);

  uart_baud_gen #(.WAIT_CYCLES(WAIT_CYCLES)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (tick)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    done         = 1'b0;
    tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next   = START;
          shift_next   = in_data;
          bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^in_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next   = STOP;
          bit_cnt_next = 3'd0;
        end
      end
`endif
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (tick) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            done         = 1'b1;
            state_next   = IDLE;
            bit_cnt_next = 3'd0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line register is loaded with the level of the state being entered,
    // so the start bit appears in the cycle right after the handshake.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= 3'd0;
      uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      uart_tx <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int WA = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int LA = (10 + NPAR) * WA;
  localparam int WB = 234;
  localparam int LB = (11 + NPAR) * WB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];  // {parity, byte}

  always #5 clk = ~clk;

  uart_tx_serializer #(.WAIT_CYCLES(WA), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a),
    .in_ready(ready_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_serializer #(.WAIT_CYCLES(WB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns right after the handshake edge.
  task automatic send_a(input logic [7:0] b, input logic par, input bit expect_frame, output int waited);
    waited  = 0;
    data_a  = b;
    valid_a = 1'b1;
    while (!ready_a && waited < 4 * LA) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_a) check("handshake_timeout", 64'(ready_a), 64'd1);
    @(posedge clk);
    if (expect_frame) exp_q.push_back({par, b});
  endtask

  // Monitor: decodes every frame on dut_a's line and checks it against the scoreboard.
  initial begin : monitor
    logic [8:0] e;
    logic [7:0] got;
    logic       par_got, start_bit, stop_bit, rdy_end, tx_end;
    int         done_at, done_n, p;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && !tx_a) begin
        got = 8'h00; par_got = 1'b0; start_bit = 1'b1; stop_bit = 1'b0;
        done_at = -1; done_n = 0; aborted = 1'b0; rdy_end = 1'b0; tx_end = 1'b0;
        for (int o = 1; o <= LA + 1; o++) begin
          if (o > 1) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (o <= LA) begin
            p = (o - 1) / WA;
            if ((o - 1) % WA == WA / 2) begin
              if (p == 0) start_bit = tx_a;
              else if (p <= 8) got[p-1] = tx_a;
              else if (NPAR == 1 && p == 9) par_got = tx_a;
              else stop_bit = tx_a;
            end
            if (done_a) begin
              done_n++;
              done_at = o;
            end
          end else begin
            rdy_end = ready_a;
            tx_end  = tx_a;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected_frame: got byte %0h, expected no frame", got);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", 64'(got), 64'(e[7:0]));
            check("frame_start_bit", 64'(start_bit), 64'd0);
            check("frame_stop_bit", 64'(stop_bit), 64'd1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 64'(par_got), 64'(e[8]));
`endif
            check("frame_done_at", 64'(done_at), 64'(LA));
            check("frame_done_count", 64'(done_n), 64'd1);
            check("frame_ready_after", 64'(rdy_end), 64'd1);
            check("frame_idle_after", 64'(tx_end), 64'd1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int         w, done_at, hi_cnt, done_b_at, done_b_n, p;
    logic [43:0] cap;
    logic [7:0] got_b;
    logic       start_b;
    bit         rdy_low_ok, saw_done;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(tx_a), 64'd1);
    check("rst_ready", 64'(ready_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", 64'(tx_a), 64'd1);
    check("post_rst_ready", 64'(ready_a), 64'd1);

    // 0x55: exact waveform, done at LA, in_ready back at LA+1
    send_a(8'h55, 1'b0, 1'b1, w);
    cap = '0;
    done_at = -1;
    for (int o = 1; o <= LA + 1; o++) begin
      @(negedge clk);
      if (o == 1) begin
        valid_a = 1'b0;
        check("t1_ready_low", 64'(ready_a), 64'd0);
        check("t1_busy", 64'(busy_a), 64'd1);
      end
      if (o <= LA) cap[o-1] = tx_a;
      if (done_a && done_at < 0) done_at = o;
      if (o == LA + 1) check("t1_ready_back", 64'(ready_a), 64'd1);
    end
`ifdef UART_TX_PARITY_EN
    check("t1_wave", 64'(cap), 64'(44'hF00F0F0F0F0));
`else
    check("t1_wave", 64'(cap), 64'(44'h0F0F0F0F0F0));
`endif
    check("t1_done_at", 64'(done_at), 64'(LA));

    // Back-to-back 0xA5, 0x3C with in_valid held
    send_a(8'hA5, 1'b0, 1'b1, w);
    @(negedge clk);
    data_a = 8'h3C;
    send_a(8'h3C, 1'b0, 1'b1, w);
    check("t2_gap", 64'(w), 64'(LA));
    @(negedge clk);
    valid_a = 1'b0;
    repeat (LA + 1) @(negedge clk);

    // 0x00 with in_valid toggling and in_data=0xFF during the frame
    send_a(8'h00, 1'b0, 1'b1, w);
    rdy_low_ok = 1'b1;
    for (int o = 1; o <= LA; o++) begin
      @(negedge clk);
      valid_a = o[0];
      data_a  = 8'hFF;
      if (ready_a) rdy_low_ok = 1'b0;
    end
    valid_a = 1'b0;
    check("t3_ready_low", 64'(rdy_low_ok), 64'd1);
    repeat (2 * LA) @(negedge clk);
    check("t3_idle", 64'(busy_a), 64'd0);

    // Reset at cycle 15 of a 0x0F frame, then 0x81
    send_a(8'h0F, 1'b0, 1'b0, w);
    for (int o = 1; o <= 15; o++) begin
      @(negedge clk);
      if (o == 1) valid_a = 1'b0;
    end
    check("t4_busy_before", 64'(busy_a), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t4_tx_rst", 64'(tx_a), 64'd1);
    check("t4_busy_rst", 64'(busy_a), 64'd0);
    check("t4_ready_rst", 64'(ready_a), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int o = 0; o < 2 * LA; o++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    check("t4_no_done", 64'(saw_done), 64'd0);
    send_a(8'h81, 1'b0, 1'b1, w);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (LA + 2) @(negedge clk);

    // Parity patterns (parity only appears on the line with the feature enabled)
    send_a(8'h07, 1'b1, 1'b1, w);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (LA + 2) @(negedge clk);
    send_a(8'h03, 1'b0, 1'b1, w);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (LA + 2) @(negedge clk);

    // Two stop bits at full rate: 0xC3
    data_b  = 8'hC3;
    valid_b = 1'b1;
    check("b_ready", 64'(ready_b), 64'd1);
    @(posedge clk);
    got_b = 8'h00; start_b = 1'b1; hi_cnt = 0; done_b_at = -1; done_b_n = 0;
    for (int o = 1; o <= LB + 1; o++) begin
      @(negedge clk);
      if (o == 1) begin
        valid_b = 1'b0;
        data_b  = 8'h00;
      end
      p = (o - 1) / WB;
      if ((o - 1) % WB == WB / 2) begin
        if (p == 0) start_b = tx_b;
        else if (p <= 8) got_b[p-1] = tx_b;
      end
      if (o > (9 + NPAR) * WB && o <= LB && tx_b) hi_cnt++;
      if (done_b) begin
        done_b_n++;
        done_b_at = o;
      end
      if (o == LB + 1) check("b_ready_after", 64'(ready_b), 64'd1);
    end
    check("b_start", 64'(start_b), 64'd0);
    check("b_byte", 64'(got_b), 64'hC3);
    check("b_stop_high", 64'(hi_cnt), 64'd468);
    check("b_done_at", 64'(done_b_at), 64'(LB));
    check("b_done_count", 64'(done_b_n), 64'd1);

    repeat (20) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
